shift_add_multiplier: RTL and testbench

//  Multi-cycle 32x32 -> 64-bit integer multiplier for the MIPS execute stage (MULT/MULTU).

---
 rtl/shift_add_multiplier.sv | 121 ++++++++++++
 tb/tb_shift_add_multiplier.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// rtl/shift_add_multiplier.sv - radix-2 shift-and-add 32x32->64 multiplier for MULT/MULTU
module thirty_two_bit_full_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {32'd0, carry_in};
endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH:0]     acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic               neg;
    logic [CW-1:0]      count;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic [WIDTH-1:0]   add_sum;
    logic               add_cout;
    logic [WIDTH:0]     upper_next;
    logic [2*WIDTH:0]   shifted;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] result;
    logic               last_iter;

    generate
        if (WIDTH == 32) begin : g_adder32
            thirty_two_bit_full_adder u_adder (
                .a         (acc_hi[WIDTH-1:0]),
                .b         (mag_a),
                .carry_in  (1'b0),
                .sum       (add_sum),
                .carry_out (add_cout)
            );
        end else begin : g_adder_beh
            assign {add_cout, add_sum} = {1'b0, acc_hi[WIDTH-1:0]} + {1'b0, mag_a};
        end
    endgenerate

    // The adder carry becomes bit WIDTH of the upper half; it is what the shift brings down.
    assign upper_next = acc_lo[0] ? {add_cout, add_sum} : acc_hi;
    assign shifted    = {upper_next, acc_lo} >> 1;
    assign product    = {acc_hi[WIDTH-1:0], acc_lo};
    assign result     = neg ? (~product + 1'b1) : product;
    assign last_iter  = (count == CW'(WIDTH - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last_iter) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mag_a   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            neg     <= 1'b0;
            count   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mag_a  <= (signed_op && a[WIDTH-1]) ? (~a + 1'b1) : a;
                        acc_lo <= (signed_op && b[WIDTH-1]) ? (~b + 1'b1) : b;
                        acc_hi <= '0;
                        neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc_hi <= shifted[2*WIDTH:WIDTH];
                    acc_lo <= shifted[WIDTH-1:0];
                    count  <= count + 1'b1;
                end
                DONE: begin
                    hi_q   <= result[2*WIDTH-1:WIDTH];
                    lo_q   <= result[WIDTH-1:0];
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb/tb_shift_add_multiplier.sv - scoreboard bench for shift_add_multiplier
module tb_shift_add_multiplier;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    typedef struct {
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        done_prev = 1'b0;
    logic [31:0] prev_hi = '0, prev_lo = '0;

    shift_add_multiplier #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .signed_op (signed_op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        if (s) return sx * sy;
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Monitor: pops the scoreboard on every done and watches hi/lo stability.
    always @(negedge clk) begin
        if (done) begin
            if (done_prev) check("done_single_cycle", 64'd1, 64'd0);
            if (sb_q.size() == 0) begin
                check("done_without_request", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("product", {hi, lo}, e.prod);
                check("latency", 64'(cyc), 64'(e.due));
            end
        end else if ((hi !== prev_hi || lo !== prev_lo) && !(hi === 32'd0 && lo === 32'd0)) begin
            check("hilo_stable", {hi, lo}, {prev_hi, prev_lo});
        end
        done_prev <= done;
        prev_hi   <= hi;
        prev_lo   <= lo;
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic s, input logic [31:0] x, input logic [31:0] y, input bit scramble);
        exp_t e;
        wait_idle();
        start = 1'b1;
        signed_op = s;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
        e.prod = ref_mul(s, x, y);
        e.due  = cyc + 33;
        sb_q.push_back(e);
        if (scramble) begin
            a = $urandom;
            b = $urandom;
            signed_op = 1'($urandom);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        issue(1'b0, 32'd3, 32'd5, 1'b0);
        issue(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0);
        issue(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(1'b1, 32'h80000000, 32'h80000000, 1'b0);
        issue(1'b0, 32'h80000000, 32'h80000000, 1'b0);

        // Start pulses while busy must be ignored.
        issue(1'b0, 32'd7, 32'd9, 1'b0);
        for (int i = 0; i < 20; i++) begin
            start = 1'($urandom);
            signed_op = 1'($urandom);
            a = $urandom;
            b = $urandom;
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        // Abort at count 10.
        issue(1'b1, $urandom, $urandom, 1'b0);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        reset = 1'b0;
        issue(1'b0, 32'd3, 32'd5, 1'b0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if (i % 6 == 0) x = 32'h80000000;
            if (i % 7 == 0) y = 32'hFFFFFFFF;
            issue(1'($urandom), x, y, 1'b1);
        end

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
